// File: rtl/clock_gen_param_if.sv
// Control and strobe bundle of the parametrised clock-enable generator.
// The master side is the generator; the slave side is its consumer.
interface clock_gen_param_if #(
    parameter int STAT_W = 16
);
    logic              turbo;
    logic              rf_enable;
    logic              pause_req;
    logic              stat_clear;
    logic              pixel_clken;
    logic              cpu_clken;
    logic              cpu_clken_noRF;
    logic              rf_cycle;
    logic              line_start;
    logic              pause_ack;
    logic              cpu_clock;
    logic [STAT_W-1:0] rf_stolen;

    modport master (
        input  turbo, rf_enable, pause_req, stat_clear,
        output pixel_clken, cpu_clken, cpu_clken_noRF,
        output rf_cycle, line_start, pause_ack,
        output cpu_clock, rf_stolen
    );

    modport slave (
        output turbo, rf_enable, pause_req, stat_clear,
        input  pixel_clken, cpu_clken, cpu_clken_noRF,
        input  rf_cycle, line_start, pause_ack,
        input  cpu_clock, rf_stolen
    );
endinterface

// File: rtl/clock_gen_param.sv
// Clock-enable generator: pixel/CPU enables, refresh slot stealing,
// turbo divisor, pause handshake and a saturating stolen-slot count.
module clock_gen_param #(
    parameter int CPU_DIVISOR   = 56,
    parameter int TURBO_DIVISOR = 4,
    parameter int PIXEL_DIVISOR = 8,
    parameter int LINE_TICKS    = 65,
    parameter int RF_FIRST      = 25,
    parameter int RF_STEP       = 10,
    parameter int RF_COUNT      = 4,
    parameter int STAT_W        = 16
) (
    input logic sys_clock,
    input logic reset,
    clock_gen_param_if.master bus
);
    localparam int CW = $clog2(CPU_DIVISOR);
    localparam int PW = $clog2(PIXEL_DIVISOR);
    localparam int LW = (LINE_TICKS > 1) ? $clog2(LINE_TICKS) : 1;

    localparam logic [CW-1:0] CPU_LAST = CW'(CPU_DIVISOR - 1);
    localparam logic [CW-1:0] TRB_LAST = CW'(TURBO_DIVISOR - 1);
    localparam logic [PW-1:0] PIX_LAST = PW'(PIXEL_DIVISOR - 1);
    localparam logic [PW-1:0] PIX_HALF = PW'(PIXEL_DIVISOR / 2);
    localparam logic [LW-1:0] LIN_LAST = LW'(LINE_TICKS - 1);

    localparam logic [0:0] RUN    = 1'b0;
    localparam logic [0:0] PAUSED = 1'b1;

    logic [PW-1:0]     pix_q, pix_d;
    logic [CW-1:0]     cpu_q, cpu_d;
    logic [LW-1:0]     line_q, line_d;
    logic              turbo_q, turbo_d;
    logic [0:0]        state_q, state_d;
    logic [STAT_W-1:0] stat_q, stat_d;

    logic slot;
    logic wrap;
    logic rf_hit;
    logic rf_now;

    assign slot = (cpu_q == '0);
    assign wrap = (cpu_q == (turbo_q ? TRB_LAST : CPU_LAST));

    assign pix_d   = (pix_q == PIX_LAST) ? '0 : pix_q + PW'(1);
    assign cpu_d   = wrap ? '0 : cpu_q + CW'(1);
    assign turbo_d = wrap ? bus.turbo : turbo_q;

    always_comb begin
        line_d = line_q;
        if (slot) begin
            line_d = (line_q == LIN_LAST) ? '0 : line_q + LW'(1);
        end
    end

    always_comb begin
        rf_hit = 1'b0;
        for (int k = 0; k < RF_COUNT; k++) begin
            if (int'(line_q) == RF_FIRST + k * RF_STEP) begin
                rf_hit = 1'b1;
            end
        end
    end

    assign rf_now = slot && bus.rf_enable && rf_hit;

    // The pause request is only looked at on slot ticks.
    always_comb begin
        state_d = state_q;
        if (slot) begin
            unique case (state_q)
                RUN:     if (bus.pause_req)  state_d = PAUSED;
                PAUSED:  if (!bus.pause_req) state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        stat_d = stat_q;
        if (bus.stat_clear) begin
            stat_d = '0;
        end else if (rf_now && stat_q != '1) begin
            stat_d = stat_q + STAT_W'(1);
        end
    end

    always_ff @(posedge sys_clock or posedge reset) begin
        if (reset) begin
            pix_q   <= '0;
            cpu_q   <= '0;
            line_q  <= '0;
            turbo_q <= 1'b0;
            state_q <= RUN;
            stat_q  <= '0;
        end else begin
            pix_q   <= pix_d;
            cpu_q   <= cpu_d;
            line_q  <= line_d;
            turbo_q <= turbo_d;
            state_q <= state_d;
            stat_q  <= stat_d;
        end
    end

    // Counters sit at zero in reset, so strobes are masked explicitly.
    assign bus.pixel_clken    = !reset && (pix_q == '0);
    assign bus.cpu_clock      = !reset && (pix_q < PIX_HALF);
    assign bus.cpu_clken_noRF = !reset && slot;
    assign bus.rf_cycle       = !reset && rf_now;
    assign bus.line_start     = !reset && slot && (line_q == '0);
    assign bus.pause_ack      = !reset && (state_q == PAUSED);
    assign bus.cpu_clken      = !reset && slot && !rf_now
                                && (state_d == RUN);
    assign bus.rf_stolen      = stat_q;
endmodule

// File: tb/tb_clock_gen_param.sv
// Directed bench for clock_gen_param: spacing, refresh, turbo, pause,
// saturating statistic (STAT_W = 3) and mid-operation reset.
module tb_clock_gen_param;
    logic sys_clock = 1'b0;
    logic reset     = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    clock_gen_param_if #(.STAT_W(3)) bus ();

    clock_gen_param #(.STAT_W(3)) dut (
        .sys_clock (sys_clock),
        .reset     (reset),
        .bus       (bus.master)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge sys_clock);
        #1;
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0:       return bus.cpu_clken_noRF;
            1:       return bus.pixel_clken;
            2:       return bus.line_start;
            default: return bus.rf_cycle;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int lim,
                            output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!sig(sel) && n < lim);
        if (!sig(sel)) chk("timeout", 32'(sel), 32'hFFFF);
    endtask

    task automatic run_line(output int en, output int rf,
                            output int bad);
        int idx;
        idx = 0;
        en  = 0;
        rf  = 0;
        bad = 0;
        for (int i = 0; i < 3640; i++) begin
            if (bus.cpu_clken_noRF) begin
                logic exp_rf;
                exp_rf = bus.rf_enable &&
                         (idx == 25 || idx == 35 ||
                          idx == 45 || idx == 55);
                if (bus.rf_cycle !== exp_rf ||
                    bus.cpu_clken !== !exp_rf) bad++;
                idx++;
            end
            if (bus.cpu_clken) en++;
            if (bus.rf_cycle) rf++;
            step();
        end
    endtask

    function automatic logic [7:0] outs();
        return {bus.pixel_clken, bus.cpu_clken,
                bus.cpu_clken_noRF, bus.rf_cycle,
                bus.line_start, bus.pause_ack,
                bus.cpu_clock, 1'b0};
    endfunction

    initial begin
        int n, en, rf, bad;
        bus.turbo      = 1'b0;
        bus.rf_enable  = 1'b0;
        bus.pause_req  = 1'b0;
        bus.stat_clear = 1'b0;

        repeat (3) step();
        chk("rst_outs", 32'(outs()), 0);
        chk("rst_stat", 32'(bus.rf_stolen), 0);

        reset = 1'b0;
        #1;
        chk("first_slot", 32'(bus.cpu_clken_noRF), 1);
        chk("first_pix", 32'(bus.pixel_clken), 1);
        chk("first_ls", 32'(bus.line_start), 1);
        chk("first_en", 32'(bus.cpu_clken), 1);
        chk("first_ack", 32'(bus.pause_ack), 0);

        wait_for(0, 200, n);
        chk("slot_gap", n, 56);
        wait_for(1, 50, n);
        chk("pix_gap", n, 8);
        for (int i = 0; i < 8; i++) begin
            chk("cpu_clock", 32'(bus.cpu_clock), (i < 4) ? 1 : 0);
            step();
        end
        wait_for(2, 5000, n);
        wait_for(2, 5000, n);
        chk("line_gap", n, 3640);

        run_line(en, rf, bad);
        chk("norf_en", en, 65);
        chk("norf_rf", rf, 0);
        chk("norf_map", bad, 0);
        chk("norf_ls", 32'(bus.line_start), 1);

        bus.rf_enable = 1'b1;
        #1;
        run_line(en, rf, bad);
        chk("rf_en", en, 61);
        chk("rf_rf", rf, 4);
        chk("rf_map", bad, 0);
        chk("stat_4", 32'(bus.rf_stolen), 4);
        run_line(en, rf, bad);
        chk("stat_sat", 32'(bus.rf_stolen), 7);
        run_line(en, rf, bad);
        chk("stat_hold", 32'(bus.rf_stolen), 7);

        wait_for(3, 5000, n);
        bus.stat_clear = 1'b1;
        step();
        bus.stat_clear = 1'b0;
        #1;
        chk("stat_clr", 32'(bus.rf_stolen), 0);
        wait_for(3, 5000, n);
        step();
        chk("stat_one", 32'(bus.rf_stolen), 1);

        wait_for(0, 200, n);
        repeat (10) step();
        bus.turbo = 1'b1;
        wait_for(0, 200, n);
        chk("trb_first", n, 46);
        wait_for(0, 200, n);
        chk("trb_gap1", n, 4);
        wait_for(0, 200, n);
        chk("trb_gap2", n, 4);
        bus.turbo = 1'b0;
        wait_for(0, 200, n);
        chk("trb_tail", n, 4);
        wait_for(0, 200, n);
        chk("trb_off", n, 56);

        bus.rf_enable = 1'b0;
        step();
        bus.pause_req = 1'b1;
        wait_for(0, 200, n);
        chk("pz_gap", n, 55);
        chk("pz_en", 32'(bus.cpu_clken), 0);
        chk("pz_raw", 32'(bus.cpu_clken_noRF), 1);
        chk("pz_ack0", 32'(bus.pause_ack), 0);
        step();
        chk("pz_ack1", 32'(bus.pause_ack), 1);
        repeat (5) step();
        bus.pause_req = 1'b0;
        repeat (5) step();
        bus.pause_req = 1'b1;
        wait_for(0, 200, n);
        chk("pz_hold_en", 32'(bus.cpu_clken), 0);
        chk("pz_hold_ack", 32'(bus.pause_ack), 1);
        step();
        bus.pause_req = 1'b0;
        wait_for(0, 200, n);
        chk("rs_en", 32'(bus.cpu_clken), 1);
        chk("rs_ack1", 32'(bus.pause_ack), 1);
        step();
        chk("rs_ack0", 32'(bus.pause_ack), 0);

        bus.turbo     = 1'b1;
        bus.pause_req = 1'b1;
        wait_for(2, 5000, n);
        wait_for(2, 5000, n);
        chk("trb_line", n, 260);
        for (int i = 0; i < 30; i++) wait_for(0, 200, n);
        chk("mr_ack", 32'(bus.pause_ack), 1);
        #3;
        reset = 1'b1;
        #1;
        chk("mr_outs", 32'(outs()), 0);
        chk("mr_stat", 32'(bus.rf_stolen), 0);
        bus.turbo     = 1'b0;
        bus.pause_req = 1'b0;
        @(negedge sys_clock);
        reset = 1'b0;
        #1;
        chk("mr_slot", 32'(bus.cpu_clken_noRF), 1);
        chk("mr_ls", 32'(bus.line_start), 1);
        chk("mr_ack0", 32'(bus.pause_ack), 0);
        wait_for(0, 200, n);
        chk("mr_gap", n, 56);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/clock_gen_param.md
# clock_gen_param

Parametrised clock-enable generator, successor to the fixed Apple-1 clock divider. From one master clock it derives the pixel enable, the CPU enable with video-RAM refresh slot stealing, and a CPU clock square wave. It adds a run-time turbo divisor, a switchable refresh stealer, a pause/acknowledge handshake for debug and DMA masters, and a saturating stolen-slot statistic. It sits at the top level and feeds the CPU, the display and the debug logic.

## Interface
- CPU_DIVISOR, 56: sys_clock ticks per CPU slot in normal mode; must be ≥ 2.
- TURBO_DIVISOR, 4: ticks per CPU slot in turbo mode; must satisfy 1 ≤ TURBO_DIVISOR ≤ CPU_DIVISOR.
- PIXEL_DIVISOR, 8: ticks per pixel enable; must be ≥ 2.
- LINE_TICKS, 65: CPU slots per scanline.
- RF_FIRST, 25: line slot index of the first refresh steal.
- RF_STEP, 10: spacing between refresh steals, in slots.
- RF_COUNT, 4: number of steals per line; RF_FIRST + (RF_COUNT-1)·RF_STEP < LINE_TICKS.
- STAT_W, 16: width of the stolen-slot counter.
- sys_clock, in, 1: master clock (CPU × 7 × 8).
- reset, in, 1: asynchronous, active-high.
- turbo, in, 1: 1 selects TURBO_DIVISOR.
- rf_enable, in, 1: 1 enables refresh stealing.
- pause_req, in, 1: request to halt CPU enables.
- stat_clear, in, 1: synchronous clear of rf_stolen.
- pixel_clken, out, 1: pixel enable, one tick wide.
- cpu_clken, out, 1: CPU enable, excluding stolen and paused slots.
- cpu_clken_noRF, out, 1: raw slot strobe.
- rf_cycle, out, 1: this slot is stolen for refresh.
- line_start, out, 1: slot 0 of a line.
- pause_ack, out, 1: CPU is halted.
- cpu_clock, out, 1: square wave at the pixel rate.
- rf_stolen, out, STAT_W: count of stolen slots, saturating.

## Operation
- **Pixel counter.** pix runs 0..PIXEL_DIVISOR-1 and wraps freely.
  - pixel_clken = (pix == 0).
  - cpu_clock = (pix < PIXEL_DIVISOR/2), using integer division.
- **Mode register.** turbo_q resets to 0. It loads `turbo` only on the tick where cpu == D-1, so it never changes mid-period.
  - D = turbo_q ? TURBO_DIVISOR : CPU_DIVISOR.
- **CPU counter.** cpu runs 0..D-1. Its width is clog2(CPU_DIVISOR).
  - slot = (cpu == 0).
  - With TURBO_DIVISOR = 1, slot is high on every tick.
- **Line counter.** line advances by one on each slot and wraps from LINE_TICKS-1 to 0. It advances in both modes.
- **Refresh decode.**
  - RF = rf_enable && line ∈ {RF_FIRST + k·RF_STEP, 0 ≤ k < RF_COUNT}.
  - rf_cycle = slot && RF.
  - line_start = slot && line == 0.
  - cpu_clken_noRF = slot.
- **Pause FSM**, states RUN and PAUSED, reset to RUN:
  - RUN, slot, pause_req = 1: move to PAUSED; cpu_clken is 0 on this slot.
  - PAUSED, slot, pause_req = 0: move to RUN; this slot's cpu_clken = !RF.
  - No transition happens on non-slot ticks.
  - pause_ack = (state == PAUSED).
  - cpu_clken = slot && !RF && next-state-is-RUN.
- **Statistic.** On each tick:
  - stat_clear = 1: rf_stolen ← 0. Clear wins over a simultaneous rf_cycle.
  - otherwise, rf_cycle = 1 and rf_stolen ≠ all-ones: rf_stolen ← rf_stolen + 1.
  - otherwise: hold. The counter saturates at 2^STAT_W - 1.

## Timing
- Reset, asynchronous: pix, cpu, line, turbo_q and rf_stolen go to 0; the FSM goes to RUN.
- While reset is high, all enables and strobes are held low:
  - pixel_clken, cpu_clken, cpu_clken_noRF, rf_cycle, line_start are 0.
  - pause_ack and cpu_clock are 0.
- First tick after reset release: slot and pixel_clken are both 1, line = 0.
  - cpu_clken = 1 unless RF_FIRST = 0.
  - line_start = 1.
- All strobes are combinational from registers and are exactly one sys_clock wide. Zero latency from counter state.
- Turbo switch latency: it takes effect at the first wrap after the change. The following slot period is the new D.
- pause_ack rises one tick after the slot that accepted the pause, and falls one tick after the resuming slot.
- pause_req changes between slots are ignored; only its value on slot ticks matters.
- rf_cycle and cpu_clken_noRF are independent of the pause state.
- In turbo mode, refresh steals still occur at their line indices, now at the faster slot rate.

## Test plan
- **Defaults, after reset.**
  - Stimulus: run with default parameters.
  - Required: cpu_clken_noRF every 56 ticks; pixel_clken every 8 ticks; cpu_clock high 4 ticks, low 4 ticks; line_start every 3640 ticks.
- **Refresh on.**
  - Stimulus: rf_enable = 1.
  - Required: line slots 25, 35, 45, 55 have cpu_clken = 0 and rf_cycle = 1, giving 61 CPU enables per line.
  - Stimulus: rf_enable = 0.
  - Required: 65 CPU enables per line, rf_cycle never high.
- **Turbo on.**
  - Stimulus: raise turbo while cpu = 10.
  - Required: next slot 46 ticks later; slots every 4 ticks thereafter.
  - Stimulus: drop turbo.
  - Required: 56-tick slot spacing resumes after the current 4-tick period.
- **Pause.**
  - Stimulus: pause_req = 1 one tick after a slot.
  - Required: next slot has cpu_clken = 0 and cpu_clken_noRF = 1; pause_ack = 1 from the following tick.
  - Stimulus: pause_req = 0.
  - Required: the next slot (not stolen) has cpu_clken = 1; pause_ack = 0 one tick later.
- **Statistic, STAT_W = 3.**
  - Stimulus: 9 stolen slots.
  - Required: rf_stolen = 7, held.
  - Stimulus: stat_clear on the same tick as an rf_cycle.
  - Required: rf_stolen = 0.
- **Mid-operation reset.**
  - Stimulus: reset asserted asynchronously at line = 30, while in PAUSED with turbo_q = 1.
  - Required: all outputs 0 immediately.
  - Stimulus: reset released.
  - Required: first tick shows slot = 1, line_start = 1, pause_ack = 0, 56-tick spacing.
